// File: rtl/qarb.sv
// qarb: merges NUM_IN dti queue streams into one ctrl-tagged stream, holding the grant for a whole transaction.
// Define QARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first arbitration in IDLE.
module qarb #(
    parameter int NUM_IN = 2,
    parameter int W_DIN  = 16,
    parameter int LVL    = 1,
    parameter int W_CTRL = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN-1:0]                din_valid_i,
    output logic [NUM_IN-1:0]                din_ready_o,
    input  logic [NUM_IN-1:0][LVL+W_DIN-1:0] din_data_i,
    output logic                             dout_valid_o,
    input  logic                             dout_ready_i,
    output logic [LVL+W_CTRL+W_DIN-1:0]      dout_data_o
);
    localparam int W_IN  = LVL + W_DIN;
    localparam int W_OUT = LVL + W_CTRL + W_DIN;

    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [W_CTRL-1:0]   lock_idx_q, lock_idx_d;
    logic                valid_q, valid_d;
    logic [W_OUT-1:0]    data_q, data_d;
`ifndef QARB_FIXED_PRIO_EN
    logic [W_CTRL-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    logic                grant_s;
    logic                load_s;
    logic                accept_s;
    logic                last_s;
    logic                take_s;
    logic [W_CTRL-1:0]   win_s;
    logic [W_IN-1:0]     win_data_s;
    int                  best_dist_s;
    int                  dist_s;

`ifndef QARB_FIXED_PRIO_EN
    function automatic logic [W_CTRL-1:0] wrap_inc(input logic [W_CTRL-1:0] idx);
        return (int'(idx) == NUM_IN - 1) ? W_CTRL'(0) : idx + W_CTRL'(1);
    endfunction
`endif

    // Winner: the lock owner when LOCKED, else the valid input nearest the search start.
    always_comb begin
        best_dist_s = NUM_IN;
        dist_s      = 0;
        take_s      = 1'b0;
        win_s       = '0;
        win_data_s  = '0;
        grant_s     = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
`ifdef QARB_FIXED_PRIO_EN
            dist_s = i;
`else
            dist_s = (i + NUM_IN - int'(rr_ptr_q)) % NUM_IN;
`endif
            take_s = din_valid_i[i] && (dist_s < best_dist_s) &&
                     ((state_q == IDLE) || (lock_idx_q == W_CTRL'(i)));
            best_dist_s = take_s ? dist_s : best_dist_s;
            win_s       = take_s ? W_CTRL'(i) : win_s;
            win_data_s  = take_s ? din_data_i[i] : win_data_s;
        end
        grant_s = (best_dist_s < NUM_IN);
    end

    // Input handshake: only the winner sees ready, and nobody does during reset.
    always_comb begin
        load_s      = !valid_q || dout_ready_i;
        accept_s    = grant_s && load_s && !rst;
        last_s      = &win_data_s[W_IN-1 -: LVL];
        din_ready_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            din_ready_o[i] = accept_s && (win_s == W_CTRL'(i));
        end
    end

    // Next state for the output register, lock FSM and search pointer.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        valid_d    = valid_q;
        data_d     = data_q;
`ifndef QARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (accept_s) begin
            valid_d = 1'b1;
            data_d  = {win_data_s[W_IN-1 -: LVL], win_s, win_data_s[W_DIN-1:0]};
            case (state_q)
                IDLE: begin
                    if (last_s) begin
                        state_d  = IDLE;
`ifndef QARB_FIXED_PRIO_EN
                        rr_ptr_d = wrap_inc(win_s);
`endif
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = win_s;
                    end
                end
                LOCKED: begin
                    if (last_s) begin
                        state_d  = IDLE;
`ifndef QARB_FIXED_PRIO_EN
                        rr_ptr_d = wrap_inc(lock_idx_q);
`endif
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (valid_q && dout_ready_i) begin
            // Drained with nothing behind it: clear so an idle output reads zero.
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers; reset drops any held beat and releases the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
`ifndef QARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
`ifndef QARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign dout_valid_o = valid_q;
    assign dout_data_o  = data_q;

endmodule
